// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared widths, command encodings and FSM states for counter_ctrl
package counter_pkg;
  localparam int DEF_WIDTH      = 26;
  localparam int DEF_PRESCALE_W = 8;

  typedef enum logic [1:0] {
    OP_NOP    = 2'd0,
    OP_START  = 2'd1,
    OP_STOP   = 2'd2,
    OP_RESUME = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/counter_ctrl_if.sv
// rtl/counter_ctrl_if.sv - command/status bundle for counter_ctrl; prescale present with TIMER_PRESCALE_EN
interface counter_ctrl_if #(
  parameter int WIDTH      = counter_pkg::DEF_WIDTH,
  parameter int PRESCALE_W = counter_pkg::DEF_PRESCALE_W
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_arg;
  logic             auto_reload;
  logic [WIDTH-1:0] data;
  logic             running;
  logic             done;
`ifdef TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] prescale;

  modport master (output cmd_valid, cmd_op, cmd_arg, auto_reload, prescale,
                  input  cmd_ready, data, running, done);
  modport slave  (input  cmd_valid, cmd_op, cmd_arg, auto_reload, prescale,
                  output cmd_ready, data, running, done);
`else
  modport master (output cmd_valid, cmd_op, cmd_arg, auto_reload,
                  input  cmd_ready, data, running, done);
  modport slave  (input  cmd_valid, cmd_op, cmd_arg, auto_reload,
                  output cmd_ready, data, running, done);
`endif
endinterface

// File: rtl/counter_core.sv
// rtl/counter_core.sv - WIDTH-bit up-counter with clear, enable and equal-to-limit flag
module counter_core #(
  parameter int WIDTH = counter_pkg::DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             eq
);
  always_ff @(posedge clk) begin
    if (!rst_n)   count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + 1'b1;
  end

  assign eq = (count == limit);
endmodule

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - start/stop/resume sequencer for counter_core; optional prescaler with TIMER_PRESCALE_EN
module counter_ctrl import counter_pkg::*; #(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic          clk,
  input  logic          rst_n,
  counter_ctrl_if.slave bus
);
  state_t           state, state_nx;
  logic [WIDTH-1:0] limit;
  logic             load_limit, clr, en, eq, tick, done_nx, acc;

  assign bus.cmd_ready = (state != ST_DONE);
  assign bus.running   = (state == ST_RUN);
  assign acc           = bus.cmd_valid && bus.cmd_ready;

`ifdef TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] psc;

  assign tick = (psc == bus.prescale);

  // Any command that changes run state restarts the divider so the first tick is a full period.
  always_ff @(posedge clk) begin
    if (!rst_n)
      psc <= '0;
    else if (acc && (bus.cmd_op == OP_START || bus.cmd_op == OP_STOP ||
                     (bus.cmd_op == OP_RESUME && state == ST_IDLE)))
      psc <= '0;
    else if (state == ST_RUN)
      psc <= tick ? '0 : psc + 1'b1;
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_nx   = state;
    load_limit = 1'b0;
    clr        = 1'b0;
    en         = 1'b0;
    done_nx    = 1'b0;
    case (state)
      ST_DONE: state_nx = ST_IDLE;
      default: begin
        // Accepted START/STOP/RESUME take priority over a coincident terminal count.
        if (acc && bus.cmd_op == OP_START) begin
          load_limit = 1'b1;
          clr        = 1'b1;
          state_nx   = ST_RUN;
        end else if (acc && bus.cmd_op == OP_STOP) begin
          state_nx = ST_IDLE;
        end else if (acc && bus.cmd_op == OP_RESUME && state == ST_IDLE) begin
          state_nx = ST_RUN;
        end else if (state == ST_RUN && tick) begin
          if (eq) begin
            done_nx = 1'b1;
            if (bus.auto_reload) clr      = 1'b1;
            else                 state_nx = ST_DONE;
          end else begin
            en = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      limit    <= '0;
      bus.done <= 1'b0;
    end else begin
      state    <= state_nx;
      bus.done <= done_nx;
      if (load_limit) limit <= bus.cmd_arg;
    end
  end

  counter_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .en    (en),
    .limit (limit),
    .count (bus.data),
    .eq    (eq)
  );
endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - scoreboard bench for counter_ctrl; covers prescaler when TIMER_PRESCALE_EN is defined
module tb_counter_ctrl;
  import counter_pkg::*;
  localparam int W = DEF_WIDTH;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  counter_ctrl_if bus ();
  counter_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [W-1:0] data;
    logic         running;
    logic         done;
    logic         ready;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;

  state_t       m_st;
  logic [W-1:0] m_data, m_limit;
  logic         m_done;
  logic [7:0]   m_psc, m_pre;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model(logic r, logic v, op_t op, logic [W-1:0] arg, logic ar);
    logic acc, tk;
    if (!r) begin
      m_st = ST_IDLE; m_data = '0; m_limit = '0; m_done = 1'b0; m_psc = '0;
      return;
    end
    acc    = v && (m_st != ST_DONE);
    m_done = 1'b0;
    if (m_st == ST_DONE) begin
      m_st = ST_IDLE;
    end else if (acc && op == OP_START) begin
      m_limit = arg; m_data = '0; m_st = ST_RUN; m_psc = '0;
    end else if (acc && op == OP_STOP) begin
      m_st = ST_IDLE; m_psc = '0;
    end else if (acc && op == OP_RESUME && m_st == ST_IDLE) begin
      m_st = ST_RUN; m_psc = '0;
    end else if (m_st == ST_RUN) begin
`ifdef TIMER_PRESCALE_EN
      tk = (m_psc == m_pre);
`else
      tk = 1'b1;
`endif
      m_psc = tk ? 8'd0 : m_psc + 8'd1;
      if (tk) begin
        if (m_data == m_limit) begin
          m_done = 1'b1;
          if (ar) m_data = '0;
          else    m_st = ST_DONE;
        end else begin
          m_data = m_data + 1'b1;
        end
      end
    end
  endtask

  task automatic step(logic r, logic v, op_t op, logic [W-1:0] arg, logic ar, string tag);
    exp_t e;
    @(negedge clk);
    rst_n           = r;
    bus.cmd_valid   = v;
    bus.cmd_op      = op;
    bus.cmd_arg     = arg;
    bus.auto_reload = ar;
    model(r, v, op, arg, ar);
    sb.push_back('{data: m_data, running: (m_st == ST_RUN), done: m_done, ready: (m_st != ST_DONE)});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, "_data"},    32'(bus.data),      32'(e.data));
    chk({tag, "_running"}, 32'(bus.running),   32'(e.running));
    chk({tag, "_done"},    32'(bus.done),      32'(e.done));
    chk({tag, "_ready"},   32'(bus.cmd_ready), 32'(e.ready));
    if (bus.done) done_cnt++;
  endtask

  task automatic nops(int n, logic ar, string tag);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, OP_NOP, '0, ar, tag);
  endtask

  initial begin
    rst_n = 1'b0; bus.cmd_valid = 1'b0; bus.cmd_op = OP_NOP; bus.cmd_arg = '0; bus.auto_reload = 1'b0;
    m_pre = 8'd0;
`ifdef TIMER_PRESCALE_EN
    bus.prescale = m_pre;
`endif
    // reset
    step(1'b0, 1'b1, OP_START, W'(9), 1'b0, "rst");
    step(1'b0, 1'b0, OP_NOP, '0, 1'b0, "rst");
    chk("rst_data", 32'(bus.data), 0);
    chk("rst_ready", 32'(bus.cmd_ready), 1);

    // one-shot to 5, then RESUME re-terminates immediately
    done_cnt = 0;
    step(1'b1, 1'b1, OP_START, W'(5), 1'b0, "os_start");
    nops(5, 1'b0, "os_cnt");
    chk("os_at5", 32'(bus.data), 5);
    step(1'b1, 1'b1, OP_STOP, '0, 1'b0, "os_term");   // cmd_ready still 1 this cycle, STOP wins
    chk("os_stop_wins_done", 32'(bus.done), 0);
    step(1'b1, 1'b1, OP_START, W'(5), 1'b0, "os_start2");
    nops(6, 1'b0, "os_cnt2");
    chk("os_done_pulse", 32'(bus.done), 1);
    chk("os_done_ready", 32'(bus.cmd_ready), 0);
    step(1'b1, 1'b1, OP_START, W'(1), 1'b0, "os_ignored_in_done");
    chk("os_idle_data", 32'(bus.data), 5);
    step(1'b1, 1'b1, OP_RESUME, '0, 1'b0, "os_resume");
    step(1'b1, 1'b0, OP_NOP, '0, 1'b0, "os_reterm");
    chk("os_reterm_done", 32'(bus.done), 1);
    nops(2, 1'b0, "os_tail");
    chk("os_done_count", done_cnt, 2);

    // auto-reload with limit 3
    done_cnt = 0;
    step(1'b1, 1'b1, OP_START, W'(3), 1'b1, "ar_start");
    nops(12, 1'b1, "ar_run");
    chk("ar_done_count", done_cnt, 3);
    step(1'b1, 1'b1, OP_STOP, '0, 1'b1, "ar_stop");

    // stop / hold / resume
    step(1'b1, 1'b1, OP_START, W'(100), 1'b0, "sr_start");
    nops(40, 1'b0, "sr_run");
    step(1'b1, 1'b1, OP_STOP, '0, 1'b0, "sr_stop");
    nops(10, 1'b0, "sr_hold");
    chk("sr_hold_data", 32'(bus.data), 40);
    step(1'b1, 1'b1, OP_RESUME, '0, 1'b0, "sr_resume");
    step(1'b1, 1'b1, OP_RESUME, '0, 1'b0, "sr_resume_in_run");
    chk("sr_resumed_41", 32'(bus.data), 41);
    step(1'b1, 1'b1, OP_STOP, '0, 1'b0, "sr_stop2");

    // limit boundaries
    step(1'b1, 1'b1, OP_START, W'(0), 1'b0, "l0_start");
    step(1'b1, 1'b0, OP_NOP, '0, 1'b0, "l0_term");
    chk("l0_done", 32'(bus.done), 1);
    nops(1, 1'b0, "l0_idle");
    done_cnt = 0;
    step(1'b1, 1'b1, OP_START, {W{1'b1}}, 1'b1, "lmax_start");
    nops(20, 1'b1, "lmax_run");
    chk("lmax_data", 32'(bus.data), 20);
    chk("lmax_no_done", done_cnt, 0);

`ifdef TIMER_PRESCALE_EN
    m_pre = 8'd3;
    bus.prescale = m_pre;
    done_cnt = 0;
    step(1'b1, 1'b1, OP_START, W'(2), 1'b0, "ps_start");
    nops(11, 1'b0, "ps_run");
    chk("ps_no_early_done", done_cnt, 0);
    step(1'b1, 1'b0, OP_NOP, '0, 1'b0, "ps_term");
    chk("ps_done_12", 32'(bus.done), 1);
    nops(1, 1'b0, "ps_idle");
`endif

    // reset mid-run
    step(1'b1, 1'b1, OP_START, W'(50), 1'b1, "mr_start");
    nops(7, 1'b1, "mr_run");
    step(1'b0, 1'b1, OP_START, W'(3), 1'b1, "mr_rst");
    chk("mr_rst_running", 32'(bus.running), 0);
    step(1'b1, 1'b0, OP_NOP, '0, 1'b0, "mr_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
